// File: rtl/spi_contactor_ctrl.sv
// SPI command engine and register bank for contactor pairs, PG shutdowns and global shutdown.
// Supervises contactor feedback per channel, latches thermal faults and forces contactors open.
module spi_contactor_ctrl #(
  parameter int WORD_LEN          = 8,
  parameter int NUM_CONTACTORS    = 4,
  parameter int FB_TIMEOUT_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs_active,
  input  logic                        rx_valid,
  input  logic [WORD_LEN-1:0]         rx_data,
  output logic [WORD_LEN-1:0]         tx_data,
  output logic                        tx_valid,
  input  logic [2*NUM_CONTACTORS-1:0] contactor_fb,
  input  logic [1:0]                  thermal_in,
  output logic [2*NUM_CONTACTORS-1:0] contactor_out,
  output logic [1:0]                  pg_shutdown,
  output logic                        shutdown_active,
  output logic                        fault_irq,
  output logic [WORD_LEN-1:0]         status_o
);
  localparam int            PW      = 2 * NUM_CONTACTORS;
  localparam int            CW      = $clog2(FB_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FB_TIMEOUT_CYCLES);

  localparam logic [WORD_LEN-1:0] CMD_RD_CONTACTOR = WORD_LEN'(8'h01);
  localparam logic [WORD_LEN-1:0] CMD_RD_FEEDBACK  = WORD_LEN'(8'h02);
  localparam logic [WORD_LEN-1:0] CMD_RD_STATUS    = WORD_LEN'(8'h03);
  localparam logic [WORD_LEN-1:0] CMD_RD_SHUTDOWN  = WORD_LEN'(8'h04);
  localparam logic [WORD_LEN-1:0] CMD_WR_CONTACTOR = WORD_LEN'(8'h81);
  localparam logic [WORD_LEN-1:0] CMD_WR_CONTROL   = WORD_LEN'(8'h82);
  localparam logic [WORD_LEN-1:0] CMD_WR_SHUTDOWN  = WORD_LEN'(8'h83);
  localparam logic [WORD_LEN-1:0] CMD_WR_PG        = WORD_LEN'(8'h84);

  typedef enum logic {IDLE, ARG} state_t;

  state_t              state;
  logic [WORD_LEN-1:0] cmd_q;
  logic [PW-1:0]       cmd_reg;
  logic [PW-1:0]       fb_meta;
  logic [PW-1:0]       fb_sync;
  logic                shutdown_req;
  logic                timeout_err;
  logic                invalid_req;
  logic [1:0]          thermal_latch;
  logic [CW-1:0]       fb_cnt [NUM_CONTACTORS];

  logic [WORD_LEN-3:0] arg_idx;
  logic                idx_ok;
  logic                exec;
  logic                cmd_known;
  logic                cmd_indexed;
  logic                inv_set;
  logic                clr_err;
  logic                timeout_hit;
  logic                force_off;
  logic [1:0]          sel_cmd;
  logic [1:0]          sel_fb;
  logic [WORD_LEN-1:0] status_w;

  assign arg_idx   = rx_data[WORD_LEN-1:2];
  // One spare bit keeps the compare exact when NUM_CONTACTORS fills the whole index range.
  assign idx_ok    = {1'b0, arg_idx} < (WORD_LEN-1)'(NUM_CONTACTORS);
  assign exec      = cs_active && rx_valid && (state == ARG);
  assign inv_set   = exec && (!cmd_known || (cmd_indexed && !idx_ok));
  assign clr_err   = exec && (cmd_q == CMD_WR_CONTROL) && rx_data[1];
  assign force_off = shutdown_req | (|thermal_latch) | timeout_err;
  assign fault_irq = timeout_err | invalid_req | (|thermal_latch);

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    cmd_known   = 1'b1;
    cmd_indexed = 1'b0;
    case (cmd_q)
      CMD_RD_CONTACTOR, CMD_RD_FEEDBACK, CMD_WR_CONTACTOR: cmd_indexed = 1'b1;
      CMD_RD_STATUS, CMD_RD_SHUTDOWN, CMD_WR_CONTROL,
      CMD_WR_SHUTDOWN, CMD_WR_PG:                          cmd_known   = 1'b1;
      default:                                             cmd_known   = 1'b0;
    endcase
  end

  always_comb begin
    sel_cmd     = '0;
    sel_fb      = '0;
    timeout_hit = 1'b0;
    for (int i = 0; i < NUM_CONTACTORS; i++) begin
      if (arg_idx == (WORD_LEN-2)'(i)) begin
        sel_cmd = cmd_reg[2*i +: 2];
        sel_fb  = fb_sync[2*i +: 2];
      end
      if (fb_cnt[i] == CNT_MAX) timeout_hit = 1'b1;
    end
  end

  always_comb begin
    status_w                        = '0;
    status_w[WORD_LEN-1]            = timeout_err;
    status_w[WORD_LEN-2]            = invalid_req;
    status_w[WORD_LEN-3:WORD_LEN-4] = thermal_latch;
  end

  // Command FSM, register bank and sticky errors; a raised error wins over clear_errors.
  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cmd_q         <= '0;
      cmd_reg       <= '0;
      pg_shutdown   <= '0;
      shutdown_req  <= 1'b0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      invalid_req   <= 1'b0;
      thermal_latch <= '0;
      timeout_err   <= 1'b0;
    end else begin
      tx_valid      <= 1'b0;
      thermal_latch <= (thermal_latch & ~{2{clr_err}}) | thermal_in;
      timeout_err   <= (timeout_err & ~clr_err) | timeout_hit;
      invalid_req   <= (invalid_req & ~clr_err) | inv_set;
      if (!cs_active) begin
        state <= IDLE;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            cmd_q <= rx_data;
            state <= ARG;
          end
          ARG: begin
            state <= IDLE;
            case (cmd_q)
              CMD_RD_CONTACTOR: begin
                tx_valid <= 1'b1;
                tx_data  <= idx_ok ? {{(WORD_LEN-2){1'b0}}, sel_cmd} : '0;
              end
              CMD_RD_FEEDBACK: begin
                tx_valid <= 1'b1;
                tx_data  <= idx_ok ? {{(WORD_LEN-2){1'b0}}, sel_fb} : '0;
              end
              CMD_RD_STATUS: begin
                tx_valid <= 1'b1;
                tx_data  <= status_w;
              end
              CMD_RD_SHUTDOWN: begin
                tx_valid <= 1'b1;
                tx_data  <= {{(WORD_LEN-3){1'b0}}, pg_shutdown, shutdown_req};
              end
              CMD_WR_CONTACTOR: begin
                for (int i = 0; i < NUM_CONTACTORS; i++)
                  if (idx_ok && arg_idx == (WORD_LEN-2)'(i)) cmd_reg[2*i +: 2] <= rx_data[1:0];
              end
              CMD_WR_CONTROL: begin
                if (rx_data[0]) begin
                  cmd_reg      <= '0;
                  pg_shutdown  <= '0;
                  shutdown_req <= 1'b0;
                end
              end
              CMD_WR_SHUTDOWN: shutdown_req <= rx_data[0];
              CMD_WR_PG:       pg_shutdown  <= rx_data[1:0];
              default:         ;
            endcase
          end
        endcase
      end
    end
  end

  // Feedback synchroniser, mismatch timers and the forced-off output stage.
  // NOTE: the per-channel counter array is reset like ordinary flops so no stale count can
  // raise a timeout straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_meta         <= '0;
      fb_sync         <= '0;
      contactor_out   <= '0;
      shutdown_active <= 1'b0;
      status_o        <= '0;
      for (int i = 0; i < NUM_CONTACTORS; i++) fb_cnt[i] <= '0;
    end else begin
      fb_meta         <= contactor_fb;
      fb_sync         <= fb_meta;
      contactor_out   <= cmd_reg & ~{PW{force_off}};
      shutdown_active <= force_off;
      status_o        <= status_w;
      for (int i = 0; i < NUM_CONTACTORS; i++) begin
        if (contactor_out[2*i +: 2] == fb_sync[2*i +: 2]) fb_cnt[i] <= '0;
        else if (fb_cnt[i] != CNT_MAX)                    fb_cnt[i] <= fb_cnt[i] + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_spi_contactor_ctrl.sv
// Self-checking bench for spi_contactor_ctrl: directed scenarios plus random frames scored
// against a register-level reference model of the command set.
module tb_spi_contactor_ctrl;
  localparam int N = 4;
  localparam int T = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs_active;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic [2*N-1:0] contactor_fb;
  logic [1:0]   thermal_in;
  logic [2*N-1:0] contactor_out;
  logic [1:0]   pg_shutdown;
  logic         shutdown_active;
  logic         fault_irq;
  logic [7:0]   status_o;

  logic         loopback;
  logic [2*N-1:0] fb_drive;

  // Plant model: contacts either follow their drive or are held at a fixed level.
  assign contactor_fb = loopback ? contactor_out : fb_drive;

  always #5 clk = ~clk;

  spi_contactor_ctrl #(
    .WORD_LEN(8), .NUM_CONTACTORS(N), .FB_TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .cs_active(cs_active), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .contactor_fb(contactor_fb),
    .thermal_in(thermal_in), .contactor_out(contactor_out), .pg_shutdown(pg_shutdown),
    .shutdown_active(shutdown_active), .fault_irq(fault_irq), .status_o(status_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the register bank should hold.
  logic [1:0] m_cmd [N];
  logic [1:0] m_pg;
  logic [1:0] m_therm;
  logic       m_shdn;
  logic       m_inv;
  logic       m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_force();
    return m_shdn || (m_therm != 2'b00) || m_to;
  endfunction

  function automatic logic m_fault();
    return m_inv || (m_therm != 2'b00) || m_to;
  endfunction

  function automatic logic [7:0] m_status();
    return {m_to, m_inv, m_therm, 4'b0000};
  endfunction

  function automatic logic [7:0] m_out();
    logic [7:0] v;
    v = '0;
    if (!m_force())
      for (int i = 0; i < N; i++) v[2*i +: 2] = m_cmd[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cmd[i] = 2'b00;
    m_pg = 2'b00; m_therm = 2'b00; m_shdn = 1'b0; m_inv = 1'b0; m_to = 1'b0;
  endtask

  // Applies one frame to the model; returns the expected response.
  task automatic model_exec(input logic [7:0] c, input logic [7:0] a,
                            output logic ev, output logic [7:0] ed);
    int idx;
    logic [1:0] d;
    idx = int'(a >> 2);
    d   = a[1:0];
    ev  = 1'b0;
    ed  = 8'h00;
    case (c)
      8'h01: begin
        ev = 1'b1;
        if (idx < N) ed = {6'b0, m_cmd[idx]}; else m_inv = 1'b1;
      end
      8'h02: begin
        ev = 1'b1;
        if (idx < N) ed = m_force() ? 8'h00 : {6'b0, m_cmd[idx]}; else m_inv = 1'b1;
      end
      8'h03: begin ev = 1'b1; ed = m_status(); end
      8'h04: begin ev = 1'b1; ed = {5'b0, m_pg, m_shdn}; end
      8'h81: if (idx < N) m_cmd[idx] = d; else m_inv = 1'b1;
      8'h82: begin
        if (a[0]) begin
          for (int i = 0; i < N; i++) m_cmd[i] = 2'b00;
          m_pg = 2'b00; m_shdn = 1'b0;
        end
        if (a[1]) begin m_inv = 1'b0; m_therm = 2'b00; m_to = 1'b0; end
      end
      8'h83: m_shdn = a[0];
      8'h84: m_pg = a[1:0];
      default: m_inv = 1'b1;
    endcase
  endtask

  // Sends command and argument; samples the response slot one cycle after the argument.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            output logic v, output logic [7:0] d);
    @(negedge clk); rx_data = c; rx_valid = 1'b1;
    @(negedge clk); rx_data = a;
    @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
    v = tx_valid;
    d = tx_data;
  endtask

  task automatic do_frame(input logic [7:0] c, input logic [7:0] a);
    logic v, ev;
    logic [7:0] d, ed;
    send_frame(c, a, v, d);
    model_exec(c, a, ev, ed);
    check($sformatf("tx_valid %02h/%02h", c, a), v, ev);
    if (ev) check($sformatf("tx_data %02h/%02h", c, a), d, ed);
    @(negedge clk);
    check($sformatf("tx_pulse %02h/%02h", c, a), tx_valid, 1'b0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, " contactor_out"},   contactor_out,   m_out());
    check({tag, " status_o"},        status_o,        m_status());
    check({tag, " shutdown_active"}, shutdown_active, m_force());
    check({tag, " pg_shutdown"},     pg_shutdown,     m_pg);
    check({tag, " fault_irq"},       fault_irq,       m_fault());
  endtask

  task automatic settle_check(input string tag);
    repeat (4) @(negedge clk);
    compare_model(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic v, ev;
    logic [7:0] d, ed;

    rst = 1'b1; cs_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    thermal_in = 2'b00; loopback = 1'b1; fb_drive = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_model("reset");
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset tx_data",  tx_data,  8'h00);
    rst = 1'b0; cs_active = 1'b1;

    // Channel 1 commanded 01 with feedback looped back: no fault over a long run.
    do_frame(8'h81, 8'h05);
    check("ch1 drive", contactor_out[3:2], 2'b01);
    repeat (2000) @(negedge clk);
    check("loopback fault_irq", fault_irq, 1'b0);
    compare_model("loopback");

    // Feedback stuck at 0: timeout after T cycles, clearable, then re-raised.
    do_frame(8'h82, 8'h01);
    settle_check("cleared");
    loopback = 1'b0; fb_drive = '0;
    repeat (3) @(negedge clk);
    send_frame(8'h81, 8'h07, v, d);
    model_exec(8'h81, 8'h07, ev, ed);
    check("wr tx_valid", v, ev);
    repeat (T - 3) @(negedge clk);
    check("early timeout", fault_irq, 1'b0);
    repeat (9) @(negedge clk);
    m_to = 1'b1;
    check("timeout status", status_o, 8'h80);
    compare_model("timeout");
    send_frame(8'h82, 8'h02, v, d);
    model_exec(8'h82, 8'h02, ev, ed);
    check("clear fault_irq", fault_irq, 1'b0);
    repeat (T + 8) @(negedge clk);
    m_to = 1'b1;
    compare_model("timeout again");
    do_frame(8'h82, 8'h03);
    loopback = 1'b1;
    settle_check("recovered");

    // Out-of-range index on a read.
    do_frame(8'h01, 8'h14);
    do_frame(8'h03, 8'h00);
    settle_check("invalid");
    check("invalid status", status_o, 8'h40);
    do_frame(8'h82, 8'h02);

    // Global shutdown hides stored commands, which return when it drops.
    do_frame(8'h81, 8'h01);
    do_frame(8'h81, 8'h06);
    do_frame(8'h81, 8'h0B);
    do_frame(8'h81, 8'h0F);
    settle_check("all written");
    do_frame(8'h83, 8'h01);
    settle_check("shutdown");
    send_frame(8'h83, 8'h00, v, d);
    model_exec(8'h83, 8'h00, ev, ed);
    @(negedge clk);
    check("restore contactor_out", contactor_out, 8'hF9);
    settle_check("restored");

    // One-cycle thermal pulse latches.
    @(negedge clk); thermal_in = 2'b10; m_therm = m_therm | 2'b10;
    @(negedge clk); thermal_in = 2'b00;
    settle_check("thermal");
    check("thermal status", status_o, 8'h20);
    do_frame(8'h84, 8'h03);
    do_frame(8'h04, 8'h00);
    do_frame(8'h82, 8'h02);
    settle_check("thermal cleared");

    // Chip select dropped mid-frame; a word while deselected is ignored.
    @(negedge clk); rx_data = 8'h81; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0; cs_active = 1'b0;
    @(negedge clk); check("cs drop tx_valid", tx_valid, 1'b0); rx_valid = 1'b1; rx_data = 8'h83;
    @(negedge clk); rx_valid = 1'b0; check("cs low tx_valid", tx_valid, 1'b0); cs_active = 1'b1;
    do_frame(8'h03, 8'h00);
    settle_check("after cs drop");

    // Asynchronous reset in the middle of a frame.
    @(negedge clk); rx_data = 8'h84; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rst = 1'b1;
    #1;
    model_reset();
    compare_model("async reset");
    check("async reset tx_data", tx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Random frames against the model, with occasional thermal pulses.
    for (int it = 0; it < 80; it++) begin
      logic [7:0] c, a;
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); thermal_in = 2'($urandom_range(1, 3)); m_therm = m_therm | thermal_in;
        @(negedge clk); thermal_in = 2'b00;
        repeat (4) @(negedge clk);
      end
      case ($urandom_range(0, 9))
        0:       c = 8'h01;
        1:       c = 8'h02;
        2:       c = 8'h03;
        3:       c = 8'h04;
        4, 5:    c = 8'h81;
        6:       c = 8'h82;
        7:       c = 8'h83;
        8:       c = 8'h84;
        default: c = 8'($urandom_range(5, 127));
      endcase
      a = {6'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      do_frame(c, a);
      settle_check($sformatf("rand %0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_contactor_ctrl.md
Name: spi_contactor_ctrl

Overview:
- Parametrised SPI command engine and register bank driving N contactor pairs (plus/minus), precharge-gate (PG) shutdowns and a global shutdown.
- Sits between the SPI slave shift PHY (word-level rx/tx) and the contactor drivers.
- Supervises contactor feedback with a per-channel mismatch timeout, latches thermal faults, and forces all contactors open on any fault or shutdown.

Parameters:
- WORD_LEN, 8, SPI word width. Must be >= 8.
- NUM_CONTACTORS, 4, number of contactor pairs. Range 1..2^(WORD_LEN-2).
- FB_TIMEOUT_CYCLES, 1000, clk cycles of command/feedback mismatch before a timeout fault. Must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cs_active  in  1  SPI chip-select asserted (already synchronised by PHY)
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received word
- rx_data  in  WORD_LEN  received word
- tx_data  out  WORD_LEN  response word for the PHY to shift next
- tx_valid  out  1  one-cycle pulse: tx_data loaded
- contactor_fb  in  2*NUM_CONTACTORS  asynchronous feedback; {plus,minus} per channel, channel i at [2i+1:2i]
- thermal_in  in  2  thermal shutdown inputs, level
- contactor_out  out  2*NUM_CONTACTORS  contactor drive; same packing as contactor_fb
- pg_shutdown  out  2  direct PG shutdown outputs
- shutdown_active  out  1  global shutdown in force (request or fault)
- fault_irq  out  1  high while any sticky error is set
- status_o  out  WORD_LEN  live status word

Behaviour:
- Reset (async): FSM=IDLE; all command regs, pg_shutdown, shutdown_req, sticky errors, timeout counters and sync flops 0. All outputs 0.
- Frame: command word, then argument word. Multiple frames are allowed per CS. cs_active low returns the FSM to IDLE in the next cycle, discarding a partial frame with no side effects. rx_valid while cs_active=0 is ignored.
- FSM states:
  - IDLE: rx_valid -> latch cmd -> ARG.
  - ARG: rx_valid -> execute -> IDLE.
  - Execution and tx_valid are registered: one cycle after the argument rx_valid.
- Commands. The argument for a WRITE_CONTACTOR or a contactor read is idx = arg[WORD_LEN-1:2], data = arg[1:0].
  - 0x01 READ_CONTACTOR: tx = zero-extended command bits of channel idx.
  - 0x02 READ_FEEDBACK: tx = zero-extended synchronised feedback of channel idx.
  - 0x03 READ_STATUS: tx = status word; arg ignored.
  - 0x04 READ_SHUTDOWN: tx = {0…, pg_shutdown[1:0], shutdown_req}.
  - 0x81 WRITE_CONTACTOR: cmd_reg[idx] <= data.
  - 0x82 WRITE_CONTROL: arg bit0 reset_req clears all cmd_regs, pg_shutdown and shutdown_req. arg bit1 clear_errors clears all sticky errors. Both bits may be set together.
  - 0x83 WRITE_SHUTDOWN: shutdown_req <= arg[0].
  - 0x84 WRITE_PG_SHUTDOWN: pg_shutdown <= arg[1:0].
- tx_valid pulses only for read commands. Writes produce no tx_valid.
- Invalid request (unknown cmd, or idx >= NUM_CONTACTORS on a contactor command): invalid_request sticky set, no register change. A read returns tx=0 with tx_valid.
- Status word, bit positions from MSB:
  - [W-1] feedback_timeout_error
  - [W-2] invalid_request
  - [W-3:W-4] thermal latch[1:0]
  - remaining bits 0
- status_o is registered from the same flops.
- Feedback: 2-flop synchroniser per bit.
- Feedback timeout counter, per channel, independent per channel:
  - Increments while contactor_out pair != synchronised feedback pair.
  - Clears to 0 on match.
  - Saturates at FB_TIMEOUT_CYCLES, and on reaching it sets feedback_timeout_error.
- Thermal: thermal_in[k]=1 sets thermal latch[k], which is sticky.
- Fault priority: set beats clear_errors in the same cycle. A persisting condition re-sets the error the next cycle.
- Forced off: contactor_out = cmd_reg & ~{force}, where force = shutdown_req | any thermal latch | feedback_timeout_error.
  - Registered: contactor_out is updated one cycle after a cmd_reg or force change.
  - cmd_reg values are retained while forced and reappear when force drops.
- shutdown_active = force (registered). fault_irq = OR of the sticky errors.
- Timeout counters keep counting while forced. The forced output of 0 is compared against feedback, so welded contacts still fault.

Test Plan:
- Reset then 0x81 0x05, feedback looped back after 2 cycles: contactor_out[3:2]=2'b01 one cycle after the argument; no fault after 2000 cycles.
- 0x81 0x07 with feedback held at 0: at FB_TIMEOUT_CYCLES, status bit7=1, fault_irq=1, contactor_out=0. Then 0x82 0x02 with feedback still 0: error clears, then re-sets.
- 0x01 0x14 (idx 5 ≥ 4): tx_valid with tx_data=0x00; a following 0x03 read returns 0x40.
- 0x83 0x01 after writes to channels 0–3: outputs all 0, shutdown_active=1. Then 0x83 0x00: stored commands reappear next cycle.
- thermal_in=2'b10 pulsed for one cycle: status 0x20 sticky, contactors off. 0x84 0x03 then 0x04 read returns 0x06.
- cs_active dropped after the command word only: no register change, no tx_valid. The next full 0x03 frame is decoded correctly. Assert rst mid-frame: all outputs 0 immediately.
